// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int IW = 17;
    localparam int AW = 16;

    // One fetched instruction together with the PC it was read from.
    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } fetch_entry_t;

    // Word-addressed sequential PC; wraps 16'hFFFF -> 16'h0000 naturally.
    function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush and
// combinational head output. Caller must not push into a full FIFO
// unless it also pops in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Flush and reset both suppress any push/pop of the same cycle.
    always_comb begin
        w_do_push = i_push & ~i_flush & ~rst;
        w_do_pop  = i_pop  & ~i_flush & ~rst;
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-stage front end: owns the PC, drives the instruction memory read
// port, queues returned instructions with their PC and hands them to decode
// through a valid/ready handshake. A redirect flushes queued work.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] im_addr,
    output logic          im_rd_en,
    input  logic [IW-1:0] im_instr,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] pc_out,
    input  logic          instr_ready
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] r_pc;
    logic [CW-1:0] w_count;
    logic          w_pop;
    logic          w_fetch;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    // Fetch gating: a full queue may still fetch when it is popped this cycle.
    always_comb begin
        instr_valid = (w_count != '0);
        w_pop       = instr_valid & instr_ready;
        w_fetch     = ~rst & ~redirect_valid & ((w_count < FULL) | w_pop);
        w_push_data = '{instr: im_instr, pc: r_pc};
    end

    // Program counter: reset beats redirect, redirect beats sequential fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_fetch) begin
            r_pc <= next_pc(r_pc);
        end
    end

    // The IM returns data on the falling edge of the fetch cycle, so the
    // push happens at the rising edge that closes that same cycle.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign im_addr   = r_pc;
    assign im_rd_en  = w_fetch;
    assign instr_out = w_head.instr;
    assign pc_out    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue with a behavioural
// 2048x17 instruction memory loaded on the falling edge.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [16:0] im_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [16:0] instr_out;
    logic [15:0] pc_out;
    logic        instr_ready;

    logic [16:0] mem [2048];

    int total;
    int bad;

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr        (im_addr),
        .im_rd_en       (im_rd_en),
        .im_instr       (im_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: output loads on the negedge of a read cycle.
    always @(negedge clk) begin
        if (im_rd_en) im_instr <= mem[im_addr[10:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input logic ready);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        instr_ready    = ready;
        tick();
        tick();
    endtask

    task automatic test_reset();
        hold_reset(1'b0);
        total++; if (instr_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", instr_valid); bad++; end
        total++; if (im_rd_en !== 1'b0) begin $display("FAIL reset_rd_en got=%b exp=0", im_rd_en); bad++; end
        total++; if (im_addr !== 16'h0000) begin $display("FAIL reset_addr got=%h exp=0000", im_addr); bad++; end
        rst = 1'b0;
        #1;
        total++; if (im_rd_en !== 1'b1) begin $display("FAIL first_rd_en got=%b exp=1", im_rd_en); bad++; end
        total++; if (im_addr !== 16'h0000) begin $display("FAIL first_addr got=%h exp=0000", im_addr); bad++; end
    endtask

    task automatic test_stream();
        logic [16:0] e;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = 17'h10000 + 17'(i);
            total++; if (instr_valid !== 1'b1) begin $display("FAIL stream_valid i=%0d got=%b exp=1", i, instr_valid); bad++; end
            total++; if (pc_out !== 16'(i)) begin $display("FAIL stream_pc i=%0d got=%h exp=%h", i, pc_out, 16'(i)); bad++; end
            total++; if (instr_out !== e) begin $display("FAIL stream_instr i=%0d got=%h exp=%h", i, instr_out, e); bad++; end
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] e;
        hold_reset(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (pc_out !== 16'h0000 || instr_valid !== 1'b1) begin
                $display("FAIL bp_head_stable i=%0d got_pc=%h got_v=%b exp_pc=0000 exp_v=1", i, pc_out, instr_valid); bad++; end
        end
        total++; if (im_rd_en !== 1'b0) begin $display("FAIL bp_rd_en got=%b exp=0", im_rd_en); bad++; end
        total++; if (im_addr !== 16'h0004) begin $display("FAIL bp_addr got=%h exp=0004", im_addr); bad++; end
        instr_ready = 1'b1;
        #1;
        total++; if (im_rd_en !== 1'b1) begin $display("FAIL bp_release_rd_en got=%b exp=1", im_rd_en); bad++; end
        for (int k = 0; k < 8; k++) begin
            e = 17'h10000 + 17'(k);
            total++; if (pc_out !== 16'(k) || instr_out !== e) begin
                $display("FAIL bp_drain k=%0d got=%h/%h exp=%h/%h", k, pc_out, instr_out, 16'(k), e); bad++; end
            tick();
        end
    endtask

    task automatic test_full_pop();
        logic [16:0] e;
        hold_reset(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++; if (im_rd_en !== 1'b0 || im_addr !== 16'h0004) begin
            $display("FAIL fp_full got_rd=%b got_addr=%h exp_rd=0 exp_addr=0004", im_rd_en, im_addr); bad++; end
        instr_ready = 1'b1;
        #1;
        total++; if (im_rd_en !== 1'b1) begin $display("FAIL fp_pop_rd_en got=%b exp=1", im_rd_en); bad++; end
        tick();
        instr_ready = 1'b0;
        #1;
        total++; if (pc_out !== 16'h0001 || instr_out !== 17'h10001) begin
            $display("FAIL fp_head got=%h/%h exp=0001/10001", pc_out, instr_out); bad++; end
        total++; if (im_rd_en !== 1'b0 || im_addr !== 16'h0005) begin
            $display("FAIL fp_still_full got_rd=%b got_addr=%h exp_rd=0 exp_addr=0005", im_rd_en, im_addr); bad++; end
        tick();
        tick();
        total++; if (im_rd_en !== 1'b0 || pc_out !== 16'h0001) begin
            $display("FAIL fp_hold got_rd=%b got_pc=%h exp_rd=0 exp_pc=0001", im_rd_en, pc_out); bad++; end
        instr_ready = 1'b1;
        for (int k = 1; k < 7; k++) begin
            e = 17'h10000 + 17'(k);
            total++; if (pc_out !== 16'(k) || instr_out !== e) begin
                $display("FAIL fp_drain k=%0d got=%h/%h exp=%h/%h", k, pc_out, instr_out, 16'(k), e); bad++; end
            tick();
        end
    endtask

    task automatic test_redirect();
        hold_reset(1'b0);
        rst = 1'b0;
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #1;
        total++; if (im_rd_en !== 1'b0) begin $display("FAIL rd_redirect_rd_en got=%b exp=0", im_rd_en); bad++; end
        total++; if (pc_out !== 16'h0000) begin $display("FAIL rd_pre_head got=%h exp=0000", pc_out); bad++; end
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0) begin $display("FAIL rd_flushed got=%b exp=0", instr_valid); bad++; end
        total++; if (im_addr !== 16'h0100 || im_rd_en !== 1'b1) begin
            $display("FAIL rd_target_fetch got_addr=%h got_rd=%b exp_addr=0100 exp_rd=1", im_addr, im_rd_en); bad++; end
        tick();
        total++; if (instr_valid !== 1'b1 || pc_out !== 16'h0100 || instr_out !== 17'h10100) begin
            $display("FAIL rd_first got=%b/%h/%h exp=1/0100/10100", instr_valid, pc_out, instr_out); bad++; end
        instr_ready = 1'b1;
        tick();
        total++; if (pc_out !== 16'h0101 || instr_out !== 17'h10101) begin
            $display("FAIL rd_second got=%h/%h exp=0101/10101", pc_out, instr_out); bad++; end
        tick();
        total++; if (pc_out !== 16'h0102) begin $display("FAIL rd_third got=%h exp=0102", pc_out); bad++; end
    endtask

    task automatic test_redirect_pop_wrap();
        hold_reset(1'b1);
        rst = 1'b0;
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        #1;
        total++; if (pc_out !== 16'h0002 || im_rd_en !== 1'b0) begin
            $display("FAIL wr_pre got_pc=%h got_rd=%b exp_pc=0002 exp_rd=0", pc_out, im_rd_en); bad++; end
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0 || im_addr !== 16'hFFFF) begin
            $display("FAIL wr_flush got_v=%b got_addr=%h exp_v=0 exp_addr=FFFF", instr_valid, im_addr); bad++; end
        tick();
        total++; if (instr_valid !== 1'b1 || pc_out !== 16'hFFFF || instr_out !== 17'h107FF) begin
            $display("FAIL wr_ffff got=%b/%h/%h exp=1/FFFF/107FF", instr_valid, pc_out, instr_out); bad++; end
        tick();
        total++; if (instr_valid !== 1'b1 || pc_out !== 16'h0000 || instr_out !== 17'h10000) begin
            $display("FAIL wr_0000 got=%b/%h/%h exp=1/0000/10000", instr_valid, pc_out, instr_out); bad++; end
        tick();
        total++; if (pc_out !== 16'h0001) begin $display("FAIL wr_0001 got=%h exp=0001", pc_out); bad++; end
    endtask

    task automatic test_reset_mid();
        hold_reset(1'b0);
        rst = 1'b0;
        tick(); tick(); tick();
        total++; if (instr_valid !== 1'b1) begin $display("FAIL rm_pre_valid got=%b exp=1", instr_valid); bad++; end
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        #1;
        total++; if (im_rd_en !== 1'b0) begin $display("FAIL rm_rd_en got=%b exp=0", im_rd_en); bad++; end
        tick();
        total++; if (instr_valid !== 1'b0 || im_addr !== 16'h0000) begin
            $display("FAIL rm_after got_v=%b got_addr=%h exp_v=0 exp_addr=0000", instr_valid, im_addr); bad++; end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        #1;
        total++; if (im_rd_en !== 1'b1 || im_addr !== 16'h0000) begin
            $display("FAIL rm_restart got_rd=%b got_addr=%h exp_rd=1 exp_addr=0000", im_rd_en, im_addr); bad++; end
        tick();
        total++; if (instr_valid !== 1'b1 || pc_out !== 16'h0000 || instr_out !== 17'h10000) begin
            $display("FAIL rm_first got=%b/%h/%h exp=1/0000/10000", instr_valid, pc_out, instr_out); bad++; end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        instr_ready    = 1'b0;
        im_instr       = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 17'h10000 + 17'(i);

        test_reset();
        test_stream();
        test_backpressure();
        test_full_pop();
        test_redirect();
        test_redirect_pop_wrap();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch-stage front end that sits directly upstream of the 2048×17 instruction memory (IM). It owns the program counter, drives the IM `addr`/`rd_en` pair, and captures each returned 17-bit instruction with its PC into a small FIFO. The decode stage drains that FIFO through a valid/ready handshake. A branch/jump redirect flushes all fetched-but-unconsumed work.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 16'h0000: PC loaded on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `im_addr`, out, 16: address to IM; equals `pc`.
- `im_rd_en`, out, 1: IM read enable.
- `im_instr`, in, 17: IM output, loaded by the IM on the falling edge.
- `redirect_valid`, in, 1: taken branch/jump from downstream.
- `redirect_pc`, in, 16: target PC.
- `instr_valid`, out, 1: FIFO head is valid.
- `instr_out`, out, 17: head instruction.
- `pc_out`, out, 16: PC of the head instruction.
- `instr_ready`, in, 1: decode accepts the head.

## Operation
- Registered state is `pc`, a FIFO of {instr, pc} entries, `count` (log2(DEPTH)+1 bits), and rd/wr pointers (log2(DEPTH) bits, wrap modulo DEPTH).
- `pop` = `instr_valid & instr_ready`.
- `im_rd_en` = `!rst & !redirect_valid & (count < DEPTH | pop)`. This is combinational. A full queue still fetches in a cycle where it is also popped.
- `im_addr` = `pc` at all times.
- The IM loads `im_instr` on the negedge of the cycle that `rd_en` is high. The block therefore pushes {`im_instr`, `pc`} at the rising edge that closes that same cycle.
- In that same edge, `pc` <= `pc + 1`. Addressing is word-based; the PC wraps 16'hFFFF → 16'h0000. No range check is made against the 2048-entry depth.
- When `redirect_valid` is high in a cycle, at the next rising edge:
  - `count` <= 0 and pointers <= 0.
  - No push and no pop (the `pop` is discarded even if `instr_ready` is high).
  - `pc` <= `redirect_pc`.
- After a redirect, the next cycle fetches `redirect_pc`. The first instruction from the target becomes valid 2 cycles after the redirect cycle.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `instr_valid` = (`count` != 0). `instr_out` and `pc_out` come straight from the FIFO head (no output register).
- Head data must stay stable while `instr_valid & !instr_ready`.
- State machine: RUN only; flush is a one-cycle action, not a state. The fetch gate is the `count`/`pop` condition above.

## Timing
Reset values:
- `pc` = `RESET_PC`, `count` = 0, pointers = 0.
- `instr_valid` = 0.
- `im_rd_en` = 0 while `rst` is high.
- `im_addr` = `RESET_PC`.

Latency and throughput:
- First cycle after reset deassertion: `im_rd_en` = 1, `im_addr` = `RESET_PC`.
- That instruction is visible on `instr_out` with `instr_valid` = 1 in the following cycle (1-cycle fetch latency).
- Steady-state throughput is 1 instruction/cycle with `instr_ready` held high.

Boundary cases:
- `instr_ready` low: the queue fills to DEPTH. The fetch then stops with `pc` pointing at the next unfetched address; no instruction is lost or duplicated.
- `rst` asserted mid-operation overrides everything, including `redirect_valid`.
- `redirect_valid` and `rst` together: reset wins.

## Structure
- `fetch_pkg` holds:
  - constants `IW`=17 and `AW`=16;
  - `typedef struct packed {logic [IW-1:0] instr; logic [AW-1:0] pc;} fetch_entry_t`.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, and head-out.
- The top level holds the PC, the fetch gating and the redirect logic.

## Test plan
- **Reset and stream:** reset, IM preloaded with `mem[i]` = 17'h10000 + i, `instr_ready` = 1. Output is 17'h10000, 17'h10001, … with `pc_out` 0, 1, … from cycle 2; one instruction per cycle, with no gaps or duplicates.
- **Back-pressure:** `instr_ready` = 0 for 10 cycles. `count` saturates at 4, `im_rd_en` falls, and `pc` holds at 4. On release, the sequence resumes at `pc_out` 0 with no loss.
- **Full plus pop:** with the queue full, pulse `instr_ready` for 1 cycle. Exactly one push and one pop occur, and `count` stays 4.
- **Redirect:** pulse `redirect_valid` with `redirect_pc` = 16'h0100 while 3 entries are queued. `instr_valid` = 0 next cycle, and the first valid output has `pc_out` = 16'h0100.
- **Redirect during pop, and PC wrap:** redirect with `instr_ready` = 1, then `redirect_pc` = 16'hFFFF. The head is not consumed twice, and the sequence shows `pc_out` 16'hFFFF then 16'h0000.
- **Reset mid-stream:** assert `rst` while the queue holds entries. Next cycle `instr_valid` = 0 and `im_addr` = `RESET_PC`.
